// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: accepts a request vector, then emits the index of
// each set bit one per handshake, lowest-first or highest-first.
module priority_encoder_seq #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [IDX_W:0]     hit_count,
    output logic               zero_flag,
    output logic               busy
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_EMIT = 1'b1;

    logic             state;
    logic [WIDTH-1:0] pending;
    logic [IDX_W:0]   hit_cnt_r;
    logic             zero_r;
    logic [IDX_W-1:0] emit_idx;
    logic [WIDTH-1:0] emit_mask;
    logic             single_bit;
    logic             emitting;

    // Later matches overwrite earlier ones, so scan direction picks the winner.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (v[i]) r = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + (IDX_W+1)'(v[i]);
        return c;
    endfunction

    assign emitting   = (state == STATE_EMIT);
    assign emit_idx   = pick_idx(pending);
    assign emit_mask  = WIDTH'(1) << emit_idx;
    // pending is never zero while emitting, so "clearing lowest bit leaves zero" means one bit left.
    assign single_bit = ((pending & (pending - WIDTH'(1))) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STATE_IDLE;
            pending   <= '0;
            hit_cnt_r <= '0;
            zero_r    <= 1'b0;
        end else begin
            zero_r <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (in_valid) begin
                        pending   <= in_data;
                        hit_cnt_r <= popcount(in_data);
                        if (in_data == '0) zero_r <= 1'b1;
                        else               state  <= STATE_EMIT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        pending <= pending & ~emit_mask;
                        if (single_bit) state <= STATE_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = !emitting;
    assign busy      = emitting;
    assign out_valid = emitting;
    assign out_idx   = emitting ? emit_idx : '0;
    assign out_last  = emitting && single_bit;
    assign hit_count = hit_cnt_r;
    assign zero_flag = zero_r;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-based model of the emitted indices.
module tb_priority_encoder_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic       a_in_ready, a_valid, a_last, a_zf, a_busy;
    logic [3:0] a_idx;
    logic [4:0] a_hc;
    logic       b_in_ready, b_valid, b_last, b_zf, b_busy;
    logic [3:0] b_idx;
    logic [4:0] b_hc;

    int nchk = 0;
    int nerr = 0;

    int qa[$];
    int qb[$];
    int mhc = 0;
    bit mzf = 1'b0;

    typedef struct {
        logic [15:0] data;
        int hc;
        int first_lsb;
        int first_msb;
    } vec_t;
    vec_t tbl[$];

    priority_encoder_seq #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_idx(a_idx), .out_valid(a_valid),
        .out_ready(out_ready), .out_last(a_last), .hit_count(a_hc),
        .zero_flag(a_zf), .busy(a_busy));

    priority_encoder_seq #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_idx(b_idx), .out_valid(b_valid),
        .out_ready(out_ready), .out_last(b_last), .hit_count(b_hc),
        .zero_flag(b_zf), .busy(b_busy));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        mhc = 0;
        mzf = 1'b0;
    endtask

    // Model update with the inputs as they were just before the edge.
    task automatic model_edge();
        mzf = 1'b0;
        if (qa.size() > 0) begin
            if (out_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
        end else if (in_valid) begin
            mhc = $countones(in_data);
            mzf = (in_data == 16'h0);
            for (int i = 0; i < 16; i++) if (in_data[i]) qa.push_back(i);
            for (int i = 15; i >= 0; i--) if (in_data[i]) qb.push_back(i);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = qa.size();
        check("a_valid", int'(a_valid), int'(sz > 0));
        check("a_idx", int'(a_idx), sz > 0 ? qa[0] : 0);
        check("a_last", int'(a_last), int'(sz == 1));
        check("a_busy", int'(a_busy), int'(sz > 0));
        check("a_in_ready", int'(a_in_ready), int'(sz == 0));
        check("a_hit_count", int'(a_hc), mhc);
        check("a_zero_flag", int'(a_zf), int'(mzf));
        check("b_valid", int'(b_valid), int'(sz > 0));
        check("b_idx", int'(b_idx), sz > 0 ? qb[0] : 0);
        check("b_last", int'(b_last), int'(sz == 1));
        check("b_in_ready", int'(b_in_ready), int'(sz == 0));
        check("b_hit_count", int'(b_hc), mhc);
        check("b_zero_flag", int'(b_zf), int'(mzf));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (a_valid && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check({name, "_drain_timeout"}, n, 0);
    endtask

    initial begin
        // Table: one-hot sweep plus a few multi-bit and boundary vectors.
        for (int k = 0; k < 16; k++) tbl.push_back('{16'(1 << k), 1, k, k});
        tbl.push_back('{16'h8421, 4, 0, 15});
        tbl.push_back('{16'h0006, 2, 1, 2});
        tbl.push_back('{16'hFFFF, 16, 0, 15});
        tbl.push_back('{16'h8000, 1, 15, 15});
        tbl.push_back('{16'h0000, 0, 0, 0});
        tbl.push_back('{16'h7FFE, 14, 1, 14});

        // Reset values, observed before any clock edge.
        #3;
        model_reset();
        compare_all();
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release accepts the first table entry.
        foreach (tbl[t]) begin
            in_data = tbl[t].data;
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check("tbl_hit_count", int'(a_hc), tbl[t].hc);
            if (tbl[t].hc == 0) begin
                check("tbl_zero_flag", int'(a_zf), 1);
                check("tbl_zero_valid", int'(a_valid), 0);
            end else begin
                check("tbl_first_lsb", int'(a_idx), tbl[t].first_lsb);
                check("tbl_first_msb", int'(b_idx), tbl[t].first_msb);
                check("tbl_first_last", int'(a_last), int'(tbl[t].hc == 1));
            end
            drain("tbl");
        end

        // 8421 streams 0,5,10,15 back-to-back, then turns around in one cycle.
        in_data = 16'h8421; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("seq8421_idx", int'(a_idx), i * 5);
            check("seq8421_last", int'(a_last), int'(i == 3));
            check("seq8421_hc", int'(a_hc), 4);
            step();
        end
        check("seq8421_in_ready", int'(a_in_ready), 1);

        // MSB-first ordering on 8001.
        in_data = 16'h8001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("msb8001_idx0", int'(b_idx), 15);
        check("msb8001_last0", int'(b_last), 0);
        step();
        check("msb8001_idx1", int'(b_idx), 0);
        check("msb8001_last1", int'(b_last), 1);
        step();

        // Backpressure holds idx 1 stable.
        in_data = 16'h0006; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("bp_hold_idx", int'(a_idx), 1);
            check("bp_hold_last", int'(a_last), 0);
            step();
        end
        check("bp_hold_idx", int'(a_idx), 1);
        out_ready = 1'b1;
        step();
        check("bp_idx2", int'(a_idx), 2);
        check("bp_last2", int'(a_last), 1);
        step();

        // Zero vector pulses zero_flag for exactly one cycle.
        in_data = 16'h0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("zero_pulse", int'(a_zf), 1);
        check("zero_valid", int'(a_valid), 0);
        check("zero_hc", int'(a_hc), 0);
        step();
        check("zero_pulse_end", int'(a_zf), 0);

        // Inputs during EMIT are ignored.
        in_data = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_data = 16'hFFFF;
        step();
        step();
        check("ignore_hc", int'(a_hc), 2);
        check("ignore_idx", int'(a_idx), 0);
        in_valid = 1'b0;
        drain("ignore");
        check("ignore_hc_hold", int'(a_hc), 2);

        // Reset after the first handshake abandons the rest.
        in_data = 16'h00F0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("rst_first_idx", int'(a_idx), 4);
        step();
        check("rst_second_idx", int'(a_idx), 5);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_async_valid", int'(a_valid), 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_emit", int'(a_valid), 0);
        end
        check("rst_hc", int'(a_hc), 0);
        check("rst_in_ready", int'(a_in_ready), 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: in_data = 16'h0;
                1: in_data = 16'(1 << $urandom_range(0, 15));
                2: in_data = 16'($urandom) & 16'($urandom);
                default: in_data = 16'($urandom);
            endcase
            in_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
